operand_entry: RTL and testbench
================================

# operand_entry

Parametrised button-driven operand entry unit for the ALU front end. It synchronises and edge-detects the raw bit-entry, store and clear buttons, and assembles a WIDTH-bit value serially in either shift direction. The unit tracks how many bits have been entered and commits the value into one of NUM_OPS operand slots, which feed the ALU datapath and the seven-segment display decoders.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- NUM_OPS, 2, number of operand slots (≥1)
- SYNC_STAGES, 2, synchroniser flops per button input (≥1)
- SELW, derived, max(1, $clog2(NUM_OPS))
- clk  input  1  single system clock; all state on rising edge
- rstn  input  1  asynchronous, active-low reset
- btn0  input  1  raw button, enter a 0 bit
- btn1  input  1  raw button, enter a 1 bit
- btn_store  input  1  raw button, commit entry to slot sel
- btn_clear  input  1  raw button, discard current entry
- dir  input  1  0 = shift left (new bit at LSB), 1 = shift right (new bit at MSB); level, sampled at the shift edge
- sel  input  SELW  target slot for store; level, sampled at the store edge
- entry  output  WIDTH  value being assembled
- count  output  $clog2(WIDTH+1)  bits entered since last clear/store, saturating at WIDTH
- full  output  1  count == WIDTH
- operands  output  NUM_OPS*WIDTH  slot i at bits [i*WIDTH +: WIDTH]
- valid  output  NUM_OPS  slot i has been written since reset
- store_done  output  1  one-cycle flag, slot write occurred this cycle

## Operation
- Each button: SYNC_STAGES-flop synchroniser, then a prev flop; pulse = sync_out & ~prev (one cycle per press; held button gives one pulse).
- Entry state: EMPTY (count 0), PARTIAL (0<count<WIDTH), FULL (count==WIDTH); derived from count, no separate state register.
- Priority per cycle, highest first: clear, store, bit entry.
- Clear pulse: entry←0, count←0; a coincident store or bit pulse is dropped.
- Store pulse, no clear: if sel < NUM_OPS then operands[sel]←entry, valid[sel]←1, store_done←1; else slot write and store_done suppressed. In both cases entry←0, count←0. A coincident bit pulse is dropped.
- Bit pulse, no clear/store: pulse0 and pulse1 together → ignored, no change. Single pulse: dir=0 → entry←{entry[WIDTH-2:0], b}; dir=1 → entry←{b, entry[WIDTH-1:1]}; count←min(count+1, WIDTH).
- FULL behaviour on further bit pulses: see Configuration.
- Storing from EMPTY writes 0 and sets valid.
- Operands and valid change only by store or rstn.

## Timing
- Reset (rstn low, asynchronous): entry=0, count=0, full=0, operands=0, valid=0, store_done=0, all synchroniser and prev flops=0. Reset mid-press: press lost; if the button is still high at release of reset, it produces one pulse SYNC_STAGES+1 edges later.
- Button high before edge k (first sampling edge): pulse high between edges k+SYNC_STAGES-1 and k+SYNC_STAGES; entry/count/operands/valid/store_done update at edge k+SYNC_STAGES.
- store_done high exactly one cycle, aligned with the operand update.
- Minimum spacing between accepted presses of one button: low for ≥1 sampled cycle.
- All outputs are registered; no combinational input→output paths.

## Configuration
- OPERAND_ENTRY_LOCK_EN defined: in FULL, bit pulses are ignored (entry and count unchanged) until clear or store.
- Not defined: in FULL, bit pulses still shift (oldest bit discarded), count stays at WIDTH.

## Test plan
- Reset, WIDTH=8: press btn1, btn0, btn1, btn1 with dir=0 → entry=8'h0B, count=4, full=0; each update 3 edges after press (SYNC_STAGES=2).
- dir=1, press btn1 eight times → entry=8'hFF, full=1; ninth press btn0 → lock build: 8'hFF, count=8; no-lock build: 8'h7F, count=8.
- Entry 8'hA5, sel=1, press btn_store → operands[15:8]=8'hA5, valid=2'b10, store_done one cycle, entry=0, count=0; sel=0 store of empty entry → operands[7:0]=0, valid=2'b11.
- NUM_OPS=3, sel=3, store → operands and valid unchanged, store_done=0, entry cleared.
- Same-cycle btn_clear+btn_store with entry 8'h3C → slots unchanged, entry=0; same-cycle btn0+btn1 → no change; button held 50 cycles → single shift.
- rstn asserted between two presses with operands loaded → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - button-driven serial operand entry with NUM_OPS operand slots
//
// Synchronises and edge-detects four raw buttons, shifts bits into a WIDTH-bit
// entry register in either direction and commits the entry to a selected slot.
//
// Optional feature macro: OPERAND_ENTRY_LOCK_EN
//   defined     : once the entry holds WIDTH bits, further bit presses are ignored
//   not defined : further bit presses keep shifting, dropping the oldest bit
//
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   btn0       in   raw button, enter a 0 bit
//   btn1       in   raw button, enter a 1 bit
//   btn_store  in   raw button, commit entry to slot sel
//   btn_clear  in   raw button, discard current entry
//   dir        in   0 = shift left (new bit at LSB), 1 = shift right (new bit at MSB)
//   sel        in   target slot for store
//   entry      out  value being assembled
//   count      out  bits entered since last clear/store, saturating at WIDTH
//   full       out  count == WIDTH
//   operands   out  slot i at [i*WIDTH +: WIDTH]
//   valid      out  slot i written since reset
//   store_done out  one-cycle flag, slot write this cycle
module operand_entry #(
    parameter int WIDTH       = 8,
    parameter int NUM_OPS     = 2,
    parameter int SYNC_STAGES = 2,
    localparam int SELW       = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    localparam int CW         = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     btn0,
    input  logic                     btn1,
    input  logic                     btn_store,
    input  logic                     btn_clear,
    input  logic                     dir,
    input  logic [SELW-1:0]          sel,
    output logic [WIDTH-1:0]         entry,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic [NUM_OPS*WIDTH-1:0] operands,
    output logic [NUM_OPS-1:0]       valid,
    output logic                     store_done
);

    // Button vector bit order: {clear, store, one, zero}
    localparam int B_ZERO  = 0;
    localparam int B_ONE   = 1;
    localparam int B_STORE = 2;
    localparam int B_CLEAR = 3;

    logic [3:0]               sync_q [SYNC_STAGES];
    logic [3:0]               sync_d [SYNC_STAGES];
    logic [3:0]               prev_q, prev_d;
    logic [3:0]               pulse;
    logic [WIDTH-1:0]         entry_q, entry_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     full_q, full_d;
    logic [NUM_OPS*WIDTH-1:0] operands_q, operands_d;
    logic [NUM_OPS-1:0]       valid_q, valid_d;
    logic                     store_done_q, store_done_d;
    logic                     bit_val;
    logic                     shift_ok;

    always_comb begin
        sync_d[0] = {btn_clear, btn_store, btn1, btn0};
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        // Rising-edge detect on the synchronised level: one pulse per press
        pulse  = sync_q[SYNC_STAGES-1] & ~prev_q;

        entry_d      = entry_q;
        count_d      = count_q;
        operands_d   = operands_q;
        valid_d      = valid_q;
        store_done_d = 1'b0;
        bit_val      = pulse[B_ONE];
`ifdef OPERAND_ENTRY_LOCK_EN
        shift_ok     = !full_q;
`else
        shift_ok     = 1'b1;
`endif

        if (pulse[B_CLEAR]) begin
            entry_d = '0;
            count_d = '0;
        end else if (pulse[B_STORE]) begin
            // Out-of-range sel matches no slot, so the write and flag are suppressed
            for (int i = 0; i < NUM_OPS; i++) begin
                if (sel == SELW'(i)) begin
                    operands_d[i*WIDTH +: WIDTH] = entry_q;
                    valid_d[i]                   = 1'b1;
                    store_done_d                 = 1'b1;
                end
            end
            entry_d = '0;
            count_d = '0;
        end else if ((pulse[B_ZERO] ^ pulse[B_ONE]) && shift_ok) begin
            if (dir) begin
                entry_d = {bit_val, entry_q[WIDTH-1:1]};
            end else begin
                entry_d = {entry_q[WIDTH-2:0], bit_val};
            end
            if (count_q != CW'(WIDTH)) begin
                count_d = count_q + CW'(1);
            end
        end

        full_d = (count_d == CW'(WIDTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q       <= '0;
            entry_q      <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            operands_q   <= '0;
            valid_q      <= '0;
            store_done_q <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q       <= prev_d;
            entry_q      <= entry_d;
            count_q      <= count_d;
            full_q       <= full_d;
            operands_q   <= operands_d;
            valid_q      <= valid_d;
            store_done_q <= store_done_d;
        end
    end

    assign entry      = entry_q;
    assign count      = count_q;
    assign full       = full_q;
    assign operands   = operands_q;
    assign valid      = valid_q;
    assign store_done = store_done_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - directed self-checking bench for operand_entry
module tb_operand_entry;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        btn0 = 1'b0, btn1 = 1'b0, btn_store = 1'b0, btn_clear = 1'b0;
    logic        dir = 1'b0;
    logic [0:0]  sel = 1'b0;
    logic [1:0]  sel2 = 2'd0;

    logic [7:0]  entry, entry2;
    logic [3:0]  count, count2;
    logic        full, full2;
    logic [15:0] operands;
    logic [23:0] operands2;
    logic [1:0]  valid;
    logic [2:0]  valid2;
    logic        store_done, store_done2;

    int tests = 0;
    int fails = 0;
    logic [7:0] a5_bits;
    logic [7:0] c3_bits;

    always #5 clk = ~clk;

    operand_entry #(.WIDTH(8), .NUM_OPS(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .btn0(btn0), .btn1(btn1),
        .btn_store(btn_store), .btn_clear(btn_clear), .dir(dir), .sel(sel),
        .entry(entry), .count(count), .full(full), .operands(operands),
        .valid(valid), .store_done(store_done)
    );

    operand_entry #(.WIDTH(8), .NUM_OPS(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .rstn(rstn), .btn0(btn0), .btn1(btn1),
        .btn_store(btn_store), .btn_clear(btn_clear), .dir(dir), .sel(sel2),
        .entry(entry2), .count(count2), .full(full2), .operands(operands2),
        .valid(valid2), .store_done(store_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // m = {clear, store, one, zero}; returns just after the update edge
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {btn_clear, btn_store, btn1, btn0} = m;
        @(negedge clk);
        {btn_clear, btn_store, btn1, btn0} = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_entry", 32'(entry), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_operands", 32'(operands), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_store_done", 32'(store_done), 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // First press with latency check: no change after 2 edges, update on the 3rd
        btn1 = 1'b1;
        @(negedge clk);
        btn1 = 1'b0;
        @(negedge clk);
        check("lat_before", 32'(entry), 32'h0);
        @(negedge clk);
        check("lat_entry", 32'(entry), 32'h1);
        check("lat_count", 32'(count), 32'h1);

        press(4'b0001);
        press(4'b0010);
        press(4'b0010);
        check("left_entry", 32'(entry), 32'h0B);
        check("left_count", 32'(count), 32'h4);
        check("left_full", 32'(full), 32'h0);

        press(4'b1000);
        check("clear_entry", 32'(entry), 32'h0);
        check("clear_count", 32'(count), 32'h0);

        dir = 1'b1;
        for (int i = 0; i < 8; i++) press(4'b0010);
        check("right_entry", 32'(entry), 32'hFF);
        check("right_count", 32'(count), 32'h8);
        check("right_full", 32'(full), 32'h1);
        press(4'b0001);
`ifdef OPERAND_ENTRY_LOCK_EN
        check("ninth_entry", 32'(entry), 32'hFF);
`else
        check("ninth_entry", 32'(entry), 32'h7F);
`endif
        check("ninth_count", 32'(count), 32'h8);
        check("ninth_full", 32'(full), 32'h1);

        press(4'b1000);
        dir = 1'b0;
        a5_bits = 8'hA5;
        for (int i = 7; i >= 0; i--) press(a5_bits[i] ? 4'b0010 : 4'b0001);
        check("a5_entry", 32'(entry), 32'hA5);
        sel = 1'b1;
        sel2 = 2'd0;
        press(4'b0100);
        check("st1_operands", 32'(operands), 32'hA500);
        check("st1_valid", 32'(valid), 32'h2);
        check("st1_done", 32'(store_done), 32'h1);
        check("st1_entry", 32'(entry), 32'h0);
        check("st1_count", 32'(count), 32'h0);
        check("st1_full", 32'(full), 32'h0);
        check("st1_op3", 32'(operands2), 32'h0000A5);
        @(negedge clk);
        check("st1_done_drop", 32'(store_done), 32'h0);

        sel = 1'b0;
        sel2 = 2'd2;
        press(4'b0100);
        check("st0_operands", 32'(operands), 32'hA500);
        check("st0_valid", 32'(valid), 32'h3);
        check("st0_done", 32'(store_done), 32'h1);
        check("st2_valid3", 32'(valid2), 32'h5);

        // Out-of-range slot on the 3-slot instance
        press(4'b0010);
        press(4'b0010);
        check("oor_entry_pre", 32'(entry2), 32'h03);
        sel = 1'b1;
        sel2 = 2'd3;
        press(4'b0100);
        check("oor_operands3", 32'(operands2), 32'h0000A5);
        check("oor_valid3", 32'(valid2), 32'h5);
        check("oor_done3", 32'(store_done2), 32'h0);
        check("oor_entry3", 32'(entry2), 32'h0);
        check("oor_count3", 32'(count2), 32'h0);
        check("oor_dut_operands", 32'(operands), 32'h0300);
        check("oor_dut_done", 32'(store_done), 32'h1);

        c3_bits = 8'h3C;
        for (int i = 7; i >= 0; i--) press(c3_bits[i] ? 4'b0010 : 4'b0001);
        check("3c_entry", 32'(entry), 32'h3C);
        press(4'b1100);
        check("clrst_operands", 32'(operands), 32'h0300);
        check("clrst_valid", 32'(valid), 32'h3);
        check("clrst_done", 32'(store_done), 32'h0);
        check("clrst_entry", 32'(entry), 32'h0);
        check("clrst_count", 32'(count), 32'h0);

        press(4'b0010);
        press(4'b0011);
        check("both_entry", 32'(entry), 32'h01);
        check("both_count", 32'(count), 32'h1);

        @(negedge clk);
        btn0 = 1'b1;
        repeat (50) @(negedge clk);
        btn0 = 1'b0;
        repeat (3) @(negedge clk);
        check("held_entry", 32'(entry), 32'h02);
        check("held_count", 32'(count), 32'h2);

        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_operands", 32'(operands), 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        check("arst_entry", 32'(entry), 32'h0);
        check("arst_count", 32'(count), 32'h0);
        check("arst_operands3", 32'(operands2), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        press(4'b0010);
        check("post_rst_entry", 32'(entry), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
